// File: rtl/memory_access.sv
// RV32I memory stage: req/ack data-memory access with store formatting and load alignment.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned or illegal accesses instead of force-aligning.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD
`define LOAD 7'b0000011
`endif
`ifndef STORE
`define STORE 7'b0100011
`endif

module memory_access #(
   parameter int AWIDTH      = 5,
   parameter int DWIDTH      = 32,
   parameter int FUNCT_WIDTH = 3,
   parameter int PC_WIDTH    = 32
) (
   input  logic                     mem_clk,
   input  logic                     mem_rst,
   input  logic                     mem_i_ce,
   input  logic                     mem_i_stall,
   input  logic                     mem_i_flush,
   input  logic [`OPCODE_WIDTH-1:0] mem_i_opcode,
   input  logic [FUNCT_WIDTH-1:0]   mem_i_funct3,
   input  logic [DWIDTH-1:0]        mem_i_alu_value,
   input  logic [DWIDTH-1:0]        mem_i_data_rs2,
   input  logic [AWIDTH-1:0]        mem_i_addr_rd,
   input  logic [DWIDTH-1:0]        mem_i_data_rd,
   input  logic                     mem_i_we_reg,
   input  logic [PC_WIDTH-1:0]      mem_i_pc,
   output logic                     mem_o_req,
   output logic                     mem_o_wr,
   output logic [DWIDTH-1:0]        mem_o_addr,
   output logic [DWIDTH-1:0]        mem_o_wdata,
   output logic [3:0]               mem_o_wstrb,
   input  logic                     mem_i_ack,
   input  logic [DWIDTH-1:0]        mem_i_rdata,
   output logic                     mem_o_ce,
   output logic                     mem_o_we_reg,
   output logic [AWIDTH-1:0]        mem_o_addr_rd,
   output logic [DWIDTH-1:0]        mem_o_data_rd,
   output logic [PC_WIDTH-1:0]      mem_o_pc,
   output logic                     mem_o_stall,
   output logic                     mem_o_exception
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   state_e                 state_q;
   logic [FUNCT_WIDTH-1:0] funct3_q;
   logic                   is_load, is_store, legal, trap;
   logic [DWIDTH-1:0]      addr_d, wdata_d, shifted, load_data_d;
   logic [3:0]             wstrb_d;
`ifdef MEM_MISALIGN_TRAP_EN
   logic                   misaligned;
   logic                   exc_q;
`endif

   assign mem_o_stall = (state_q == BUSY);

   always_comb begin
      is_load  = (mem_i_opcode == `LOAD);
      is_store = (mem_i_opcode == `STORE);
      legal    = is_load ? !(mem_i_funct3 == 3'b011 || mem_i_funct3 == 3'b110 ||
                             mem_i_funct3 == 3'b111)
                         : (mem_i_funct3 < 3'b011);
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned = (mem_i_funct3[1:0] == 2'b01 && mem_i_alu_value[0]) ||
                   (mem_i_funct3[1:0] == 2'b10 && mem_i_alu_value[1:0] != 2'b00);
      trap       = !legal || misaligned;
`else
      trap       = !legal;
`endif
      // Without the trap, halfword/word accesses are silently aligned down.
      addr_d = mem_i_alu_value;
      if (mem_i_funct3[1:0] == 2'b01) addr_d[0] = 1'b0;
      if (mem_i_funct3[1:0] == 2'b10) addr_d[1:0] = 2'b00;
      case (mem_i_funct3[1:0])
         2'b00: begin
            wstrb_d = 4'b0001 << addr_d[1:0];
            wdata_d = {4{mem_i_data_rs2[7:0]}};
         end
         2'b01: begin
            wstrb_d = 4'b0011 << {addr_d[1], 1'b0};
            wdata_d = {2{mem_i_data_rs2[15:0]}};
         end
         default: begin
            wstrb_d = 4'b1111;
            wdata_d = mem_i_data_rs2;
         end
      endcase
   end

   // Load extraction uses the latched request, not the live execute-stage inputs.
   always_comb begin
      shifted = mem_i_rdata >> {mem_o_addr[1:0], 3'b000};
      case (funct3_q)
         3'b000:  load_data_d = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_data_d = {24'd0, shifted[7:0]};
         3'b001:  load_data_d = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_data_d = {16'd0, shifted[15:0]};
         default: load_data_d = shifted;
      endcase
   end

   always_ff @(posedge mem_clk or negedge mem_rst) begin
      if (!mem_rst) begin
         state_q       <= IDLE;
         funct3_q      <= '0;
         mem_o_req     <= 1'b0;
         mem_o_wr      <= 1'b0;
         mem_o_addr    <= '0;
         mem_o_wdata   <= '0;
         mem_o_wstrb   <= 4'b0000;
         mem_o_ce      <= 1'b0;
         mem_o_we_reg  <= 1'b0;
         mem_o_addr_rd <= '0;
         mem_o_data_rd <= '0;
         mem_o_pc      <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         exc_q         <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (!mem_i_stall) begin
`ifdef MEM_MISALIGN_TRAP_EN
                  exc_q <= 1'b0;
`endif
                  if (!mem_i_ce || mem_i_flush) begin
                     mem_o_ce     <= 1'b0;
                     mem_o_we_reg <= 1'b0;
                  end else if (!(is_load || is_store)) begin
                     mem_o_ce      <= 1'b1;
                     mem_o_we_reg  <= mem_i_we_reg;
                     mem_o_data_rd <= mem_i_data_rd;
                     mem_o_addr_rd <= mem_i_addr_rd;
                     mem_o_pc      <= mem_i_pc;
                  end else if (trap) begin
                     mem_o_ce      <= 1'b1;
                     mem_o_we_reg  <= 1'b0;
                     mem_o_addr_rd <= mem_i_addr_rd;
                     mem_o_pc      <= mem_i_pc;
`ifdef MEM_MISALIGN_TRAP_EN
                     exc_q         <= 1'b1;
`endif
                  end else begin
                     state_q       <= BUSY;
                     funct3_q      <= mem_i_funct3;
                     mem_o_ce      <= 1'b0;
                     mem_o_we_reg  <= 1'b0;
                     mem_o_req     <= 1'b1;
                     mem_o_wr      <= is_store;
                     mem_o_addr    <= addr_d;
                     mem_o_wstrb   <= is_store ? wstrb_d : 4'b0000;
                     mem_o_wdata   <= wdata_d;
                     mem_o_addr_rd <= mem_i_addr_rd;
                     mem_o_pc      <= mem_i_pc;
                  end
               end
            end
            BUSY: begin
               if (mem_i_ack) begin
                  state_q      <= IDLE;
                  mem_o_req    <= 1'b0;
                  mem_o_ce     <= 1'b1;
                  mem_o_we_reg <= !mem_o_wr;
                  if (!mem_o_wr) mem_o_data_rd <= load_data_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign mem_o_exception = exc_q;
`else
   assign mem_o_exception = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Directed and randomized checks of memory_access (default build) against a byte-lane reference model.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD
`define LOAD 7'b0000011
`endif
`ifndef STORE
`define STORE 7'b0100011
`endif

module tb_memory_access;
   localparam logic [6:0] OP_ALU = 7'b0110011;

   logic        mem_clk = 1'b0;
   logic        mem_rst = 1'b0;
   logic        mem_i_ce = 1'b0, mem_i_stall = 1'b0, mem_i_flush = 1'b0;
   logic [6:0]  mem_i_opcode = '0;
   logic [2:0]  mem_i_funct3 = '0;
   logic [31:0] mem_i_alu_value = '0, mem_i_data_rs2 = '0, mem_i_data_rd = '0;
   logic [4:0]  mem_i_addr_rd = '0;
   logic        mem_i_we_reg = 1'b0;
   logic [31:0] mem_i_pc = '0;
   logic        mem_i_ack = 1'b0;
   logic [31:0] mem_i_rdata = '0;
   logic        mem_o_req, mem_o_wr, mem_o_ce, mem_o_we_reg, mem_o_stall, mem_o_exception;
   logic [31:0] mem_o_addr, mem_o_wdata, mem_o_data_rd, mem_o_pc;
   logic [3:0]  mem_o_wstrb;
   logic [4:0]  mem_o_addr_rd;

   int total = 0;
   int bad   = 0;

   always #5 mem_clk = ~mem_clk;

   memory_access #(.AWIDTH(5), .DWIDTH(32), .FUNCT_WIDTH(3), .PC_WIDTH(32)) dut (
      .mem_clk(mem_clk), .mem_rst(mem_rst), .mem_i_ce(mem_i_ce), .mem_i_stall(mem_i_stall),
      .mem_i_flush(mem_i_flush), .mem_i_opcode(mem_i_opcode), .mem_i_funct3(mem_i_funct3),
      .mem_i_alu_value(mem_i_alu_value), .mem_i_data_rs2(mem_i_data_rs2),
      .mem_i_addr_rd(mem_i_addr_rd), .mem_i_data_rd(mem_i_data_rd), .mem_i_we_reg(mem_i_we_reg),
      .mem_i_pc(mem_i_pc), .mem_o_req(mem_o_req), .mem_o_wr(mem_o_wr), .mem_o_addr(mem_o_addr),
      .mem_o_wdata(mem_o_wdata), .mem_o_wstrb(mem_o_wstrb), .mem_i_ack(mem_i_ack),
      .mem_i_rdata(mem_i_rdata), .mem_o_ce(mem_o_ce), .mem_o_we_reg(mem_o_we_reg),
      .mem_o_addr_rd(mem_o_addr_rd), .mem_o_data_rd(mem_o_data_rd), .mem_o_pc(mem_o_pc),
      .mem_o_stall(mem_o_stall), .mem_o_exception(mem_o_exception)
   );

   task automatic tick();
      @(posedge mem_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: access size from funct3, aligned-down base, then pick bytes lane by lane.
   function automatic int acc_size(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
      int sz, off;
      logic [31:0] v;
      logic sgn;
      sz  = acc_size(f3);
      off = int'((addr - (addr % sz)) % 4);
      v   = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
      sgn = !f3[2] && v[8*sz-1];
      for (int i = sz; i < 4; i++) v[8*i +: 8] = sgn ? 8'hFF : 8'h00;
      return v;
   endfunction

   task automatic run_mem(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata, input int ack_wait,
                          input logic [4:0] rd, input logic [31:0] pc);
      int sz, off;
      logic [31:0] base, exp_wdata;
      logic [3:0]  exp_strb;
      sz   = acc_size(f3);
      base = addr - (addr % sz);
      off  = int'(base % 4);
      exp_strb  = '0;
      exp_wdata = '0;
      for (int i = 0; i < 4; i++) begin
         exp_wdata[8*i +: 8] = rs2[8*(i % sz) +: 8];
         if (st && i >= off && i < off + sz) exp_strb[i] = 1'b1;
      end
      mem_i_ce = 1'b1; mem_i_flush = 1'b0; mem_i_stall = 1'b0;
      mem_i_opcode = st ? `STORE : `LOAD; mem_i_funct3 = f3; mem_i_alu_value = addr;
      mem_i_data_rs2 = rs2; mem_i_addr_rd = rd; mem_i_pc = pc;
      mem_i_data_rd = $urandom; mem_i_we_reg = 1'b1;
      tick();
      chk("req_first", 32'(mem_o_req), 32'd1);
      chk("wr", 32'(mem_o_wr), 32'(st));
      chk("addr", mem_o_addr, base);
      chk("wstrb", 32'(mem_o_wstrb), 32'(exp_strb));
      if (st) chk("wdata", mem_o_wdata, exp_wdata);
      chk("stall_busy", 32'(mem_o_stall), 32'd1);
      chk("ce_busy", 32'(mem_o_ce), 32'd0);
      for (int k = 0; k < ack_wait + 1; k++) begin
         // Execute-stage inputs churn while busy; the in-flight access must not notice.
         mem_i_ce = 1'($urandom_range(0, 1)); mem_i_flush = 1'($urandom_range(0, 1));
         mem_i_stall = 1'($urandom_range(0, 1)); mem_i_funct3 = 3'($urandom);
         mem_i_alu_value = $urandom; mem_i_opcode = OP_ALU;
         if (k == ack_wait) begin
            mem_i_ack = 1'b1; mem_i_rdata = rdata;
         end
         tick();
         if (k < ack_wait) begin
            chk("req_hold", 32'(mem_o_req), 32'd1);
            chk("addr_hold", mem_o_addr, base);
            chk("stall_hold", 32'(mem_o_stall), 32'd1);
         end
      end
      mem_i_ack = 1'b0; mem_i_ce = 1'b0; mem_i_flush = 1'b0; mem_i_stall = 1'b0;
      chk("ce_done", 32'(mem_o_ce), 32'd1);
      chk("we_done", 32'(mem_o_we_reg), 32'(!st));
      chk("req_done", 32'(mem_o_req), 32'd0);
      chk("stall_done", 32'(mem_o_stall), 32'd0);
      chk("rd_done", 32'(mem_o_addr_rd), 32'(rd));
      chk("pc_done", mem_o_pc, pc);
      if (!st) chk("load_data", mem_o_data_rd, ref_load(f3, addr, rdata));
   endtask

   task automatic run_alu(input logic flush, input logic [31:0] data, input logic [4:0] rd,
                          input logic we, input logic [31:0] pc);
      mem_i_ce = 1'b1; mem_i_flush = flush; mem_i_stall = 1'b0; mem_i_opcode = OP_ALU;
      mem_i_data_rd = data; mem_i_addr_rd = rd; mem_i_we_reg = we; mem_i_pc = pc;
      mem_i_funct3 = 3'($urandom); mem_i_alu_value = $urandom;
      tick();
      mem_i_ce = 1'b0; mem_i_flush = 1'b0;
      chk("alu_ce", 32'(mem_o_ce), 32'(!flush));
      chk("alu_we", 32'(mem_o_we_reg), 32'(we && !flush));
      chk("alu_req", 32'(mem_o_req), 32'd0);
      if (!flush) begin
         chk("alu_data", mem_o_data_rd, data);
         chk("alu_rd", 32'(mem_o_addr_rd), 32'(rd));
         chk("alu_pc", mem_o_pc, pc);
      end
   endtask

   initial begin
      logic [2:0] ld_f3 [5];
      logic [31:0] held;
      ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

      // Reset state
      #12;
      chk("rst_req", 32'(mem_o_req), 32'd0);
      chk("rst_ce", 32'(mem_o_ce), 32'd0);
      chk("rst_we", 32'(mem_o_we_reg), 32'd0);
      chk("rst_stall", 32'(mem_o_stall), 32'd0);
      chk("rst_addr", mem_o_addr, 32'd0);
      chk("rst_wstrb", 32'(mem_o_wstrb), 32'd0);
      chk("rst_data", mem_o_data_rd, 32'd0);
      chk("rst_exc", 32'(mem_o_exception), 32'd0);
      @(negedge mem_clk);
      mem_rst = 1'b1;

      // Directed plan items
      run_mem(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 5'd3, 32'h1000);
      run_mem(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 5'd4, 32'h1004);
      run_mem(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1, 5'd5, 32'h1008);
      run_mem(1'b0, 3'b101, 32'h102, 32'h0, 32'h80123456, 0, 5'd6, 32'h100C);
      run_mem(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1, 5'd0, 32'h1010);
      run_alu(1'b0, 32'h55, 5'd7, 1'b1, 32'h1014);
      run_alu(1'b1, 32'h55, 5'd7, 1'b1, 32'h1018);
      run_mem(1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 5'd8, 32'h101C);
      chk("no_exc", 32'(mem_o_exception), 32'd0);

      // Downstream stall in IDLE holds the previous result
      run_alu(1'b0, 32'hA5A5, 5'd9, 1'b1, 32'h1020);
      held = mem_o_data_rd;
      mem_i_ce = 1'b1; mem_i_stall = 1'b1; mem_i_opcode = OP_ALU; mem_i_data_rd = 32'h1111;
      mem_i_addr_rd = 5'd10;
      tick();
      chk("stall_ce_hold", 32'(mem_o_ce), 32'd1);
      chk("stall_data_hold", mem_o_data_rd, held);
      chk("stall_rd_hold", 32'(mem_o_addr_rd), 32'd9);
      mem_i_ce = 1'b0; mem_i_stall = 1'b0;
      tick();
      chk("bubble_ce", 32'(mem_o_ce), 32'd0);

      // Ack while idle is ignored
      mem_i_ack = 1'b1;
      tick();
      mem_i_ack = 1'b0;
      chk("idle_ack_req", 32'(mem_o_req), 32'd0);
      chk("idle_ack_ce", 32'(mem_o_ce), 32'd0);

      // Illegal funct3 for load and store
      mem_i_ce = 1'b1; mem_i_opcode = `LOAD; mem_i_funct3 = 3'b011; mem_i_addr_rd = 5'd11;
      mem_i_pc = 32'h1030;
      tick();
      chk("ill_ld_req", 32'(mem_o_req), 32'd0);
      chk("ill_ld_ce", 32'(mem_o_ce), 32'd1);
      chk("ill_ld_we", 32'(mem_o_we_reg), 32'd0);
      chk("ill_ld_stall", 32'(mem_o_stall), 32'd0);
      mem_i_opcode = `STORE; mem_i_funct3 = 3'b100;
      tick();
      mem_i_ce = 1'b0;
      chk("ill_st_req", 32'(mem_o_req), 32'd0);
      chk("ill_st_ce", 32'(mem_o_ce), 32'd1);
      chk("ill_st_exc", 32'(mem_o_exception), 32'd0);

      // Reset while busy abandons the access
      mem_i_ce = 1'b1; mem_i_opcode = `LOAD; mem_i_funct3 = 3'b010; mem_i_alu_value = 32'h40;
      tick();
      mem_i_ce = 1'b0;
      chk("pre_rst_req", 32'(mem_o_req), 32'd1);
      #2 mem_rst = 1'b0;
      #1;
      chk("mid_rst_req", 32'(mem_o_req), 32'd0);
      chk("mid_rst_stall", 32'(mem_o_stall), 32'd0);
      chk("mid_rst_addr", mem_o_addr, 32'd0);
      @(negedge mem_clk);
      mem_rst = 1'b1;
      run_mem(1'b1, 3'b010, 32'h0, 32'h89ABCDEF, 32'h0, 0, 5'd1, 32'h2000);

      // Randomized mix
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0: run_mem(1'b0, ld_f3[$urandom_range(0, 4)], $urandom, 32'h0, $urandom,
                       int'($urandom_range(0, 3)), 5'($urandom), $urandom);
            1: run_mem(1'b1, 3'($urandom_range(0, 2)), $urandom, $urandom, 32'h0,
                       int'($urandom_range(0, 3)), 5'($urandom), $urandom);
            default: run_alu(1'($urandom_range(0, 1)), $urandom, 5'($urandom),
                             1'($urandom_range(0, 1)), $urandom);
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
